// File: rtl/gate_ctl.sv
// Pressure-plate gate controller: two plates request the gate, which ramps open
// one STEP per frame, holds while requested, then ramps closed again.
module gate_ctl #(
   parameter int BTN1_XMIN   = 100,
   parameter int BTN1_XMAX   = 140,
   parameter int BTN2_XMIN   = 520,
   parameter int BTN2_XMAX   = 560,
   parameter int GATE_MAX    = 96,
   parameter int STEP        = 2,
   parameter int HOLD_FRAMES = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        v_tick,
   input  logic [11:0] xpos_player1,
   input  logic [11:0] xpos_player2,
   output logic [1:0]  button_pressed,
   output logic [7:0]  gate_height,
   output logic        gate_open,
   output logic [1:0]  gate_state
);

   typedef enum logic [1:0] {
      CLOSED  = 2'd0,
      OPENING = 2'd1,
      OPEN    = 2'd2,
      CLOSING = 2'd3
   } state_t;

   localparam logic [11:0] B1_LO = 12'(BTN1_XMIN);
   localparam logic [11:0] B1_HI = 12'(BTN1_XMAX);
   localparam logic [11:0] B2_LO = 12'(BTN2_XMIN);
   localparam logic [11:0] B2_HI = 12'(BTN2_XMAX);
   localparam logic [8:0]  STEP9 = 9'(STEP);
   localparam logic [8:0]  GMAX9 = 9'(GATE_MAX);
   localparam logic [7:0]  HOLD8 = 8'(HOLD_FRAMES);

   state_t      state_reg;
   logic [8:0]  height_reg;
   logic [7:0]  hold_cnt_reg;
   logic        vtick_reg;
   logic [1:0]  btn_reg;
   logic        open_reg;

   logic        frame;
   logic [1:0]  btn_next;
   logic        req;
   logic [8:0]  height_up;

   assign frame       = v_tick & ~vtick_reg;
   assign btn_next[0] = (xpos_player1 >= B1_LO) && (xpos_player1 <= B1_HI);
   assign btn_next[1] = (xpos_player2 >= B2_LO) && (xpos_player2 <= B2_HI);
   assign req         = |btn_next;
   // 9-bit sum so height + STEP can exceed 255 without wrapping
   assign height_up   = height_reg + STEP9;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= CLOSED;
         height_reg   <= 9'd0;
         hold_cnt_reg <= 8'd0;
         vtick_reg    <= 1'b0;
         btn_reg      <= 2'b00;
         open_reg     <= 1'b0;
      end else begin
         vtick_reg <= v_tick;
         if (frame) begin
            btn_reg  <= btn_next;
            open_reg <= 1'b0;
            case (state_reg)
               CLOSED: begin
                  if (req) state_reg <= OPENING;
               end
               OPENING: begin
                  if (!req) begin
                     state_reg <= CLOSING;
                  end else if (height_up >= GMAX9) begin
                     height_reg   <= GMAX9;
                     state_reg    <= OPEN;
                     hold_cnt_reg <= HOLD8;
                     open_reg     <= 1'b1;
                  end else begin
                     height_reg <= height_up;
                  end
               end
               OPEN: begin
                  if (req) begin
                     hold_cnt_reg <= HOLD8;
                     open_reg     <= 1'b1;
                  end else if (hold_cnt_reg == 8'd0) begin
                     state_reg <= CLOSING;
                  end else begin
                     hold_cnt_reg <= hold_cnt_reg - 8'd1;
                     open_reg     <= 1'b1;
                  end
               end
               CLOSING: begin
                  if (req) begin
                     state_reg <= OPENING;
                  end else if (height_reg <= STEP9) begin
                     height_reg <= 9'd0;
                     state_reg  <= CLOSED;
                  end else begin
                     height_reg <= height_reg - STEP9;
                  end
               end
               default: begin
                  state_reg    <= CLOSED;
                  height_reg   <= 9'd0;
                  hold_cnt_reg <= 8'd0;
               end
            endcase
         end
      end
   end

   assign button_pressed = btn_reg;
   assign gate_height    = height_reg[7:0];
   assign gate_open      = open_reg;
   assign gate_state     = state_reg;

endmodule
